cplx_accum: RTL

Downstream stage of the complex multiplier `top`. It consumes the 24-bit signed product stream (`Pr`, `Pi`) and accumulates a programmable number of consecutive products into a complex sum, so `top` plus this block form a complex MAC / dot-product unit. Each block of products yields one saturated complex result. The result is presented on a valid/ready output handshake, with a per-block overflow flag.

---
 rtl/cplx_pkg.sv | 25 ++
 rtl/sat_add.sv | 36 +++
 rtl/cplx_accum.sv | 113 +++++++++++
 3 files changed

// File: rtl/cplx_pkg.sv
// ============================================================================
// Module : cplx_pkg
// Shared widths, FSM encodings and saturation limits for the complex MAC path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cplx_pkg;

  localparam int CPLX_IN_W  = 24;
  localparam int CPLX_ACC_W = 32;
  localparam int CPLX_CNT_W = 8;

  localparam logic [CPLX_ACC_W-1:0] CPLX_ACC_MAX = {1'b0, {(CPLX_ACC_W-1){1'b1}}};
  localparam logic [CPLX_ACC_W-1:0] CPLX_ACC_MIN = {1'b1, {(CPLX_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_add.sv
// ============================================================================
// Module : sat_add
// Signed W-bit add that clamps to the representable range and flags clamping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

  logic [W:0] w_wide;

  assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

  // Top two bits disagree only when the true sum left the W-bit range.
  always_comb begin
    o_sum = w_wide[W-1:0];
    o_ovf = 1'b0;
    if (w_wide[W] != w_wide[W-1]) begin
      o_ovf = 1'b1;
      o_sum = w_wide[W] ? c_min : c_max;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cplx_accum.sv
// ============================================================================
// Module : cplx_accum
// Accumulates len complex products into one saturated sum per block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cplx_accum
  import cplx_pkg::*;
#(
  parameter int IN_W  = CPLX_IN_W,
  parameter int ACC_W = CPLX_ACC_W,
  parameter int CNT_W = CPLX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   pr,
  input  logic [IN_W-1:0]   pi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sr,
  output logic [ACC_W-1:0]  si,
  output logic              ovf,
  output logic              busy
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len_q;
  logic [ACC_W-1:0]   r_acc_r;
  logic [ACC_W-1:0]   r_acc_i;
  logic               r_ovf;

  logic               w_in_fire;
  logic [CNT_W-1:0]   w_len_eff;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [ACC_W-1:0]   w_ext_r;
  logic [ACC_W-1:0]   w_ext_i;
  logic [ACC_W-1:0]   w_sum_r;
  logic [ACC_W-1:0]   w_sum_i;
  logic               w_ovf_r;
  logic               w_ovf_i;

  assign w_in_fire = in_valid & in_ready;
  assign w_len_eff = (len == '0) ? CNT_W'(1) : len;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_ext_r   = ACC_W'($signed(pr));
  assign w_ext_i   = ACC_W'($signed(pi));

  sat_add #(.W(ACC_W)) u_sat_r (
    .i_a   (r_acc_r),
    .i_b   (w_ext_r),
    .o_sum (w_sum_r),
    .o_ovf (w_ovf_r)
  );

  sat_add #(.W(ACC_W)) u_sat_i (
    .i_a   (r_acc_i),
    .i_b   (w_ext_i),
    .o_sum (w_sum_i),
    .o_ovf (w_ovf_i)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_in_fire) w_next = (w_len_eff == CNT_W'(1)) ? ST_DONE : ST_ACC;
      ST_ACC:  if (w_in_fire && (w_cnt_inc == r_len_q)) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_acc_r <= '0;
      r_acc_i <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_in_fire && r_state == ST_IDLE) begin
        r_len_q <= w_len_eff;
        r_acc_r <= w_ext_r;
        r_acc_i <= w_ext_i;
        r_cnt   <= CNT_W'(1);
        r_ovf   <= 1'b0;
      end else if (w_in_fire && r_state == ST_ACC) begin
        r_acc_r <= w_sum_r;
        r_acc_i <= w_sum_i;
        r_cnt   <= w_cnt_inc;
        r_ovf   <= r_ovf | w_ovf_r | w_ovf_i;
      end
    end
  end

  // Holding in_ready low during reset keeps a beat from being presented as taken.
  assign in_ready  = ~rst & (r_state != ST_DONE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_ACC);
  assign sr        = out_valid ? r_acc_r : '0;
  assign si        = out_valid ? r_acc_i : '0;
  assign ovf       = out_valid & r_ovf;

endmodule

`default_nettype wire
